// File: rtl/voice_allocator.sv
`default_nettype none
// ============================================================================
// Module   : voice_allocator
// Brief    : Polyphonic note-to-voice allocator with oldest-voice stealing.
//            Scans one voice per cycle, then commits the event in one edge.
// Revision : 1.0 - initial release
// ============================================================================
module voice_allocator #(
    parameter int VOICES = 8,
    parameter int WIDTH  = 24
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       panic,
    input  logic                       ev_valid,
    output logic                       ev_ready,
    input  logic                       ev_on,
    input  logic [6:0]                 ev_key,
    input  logic [15:0]                ev_freq,
    input  logic [WIDTH-1:0]           ev_amplitude,
    input  logic [1:0]                 ev_shape,
    output logic [VOICES-1:0]          voice_enable,
    output logic [16*VOICES-1:0]       voice_freq,
    output logic [WIDTH*VOICES-1:0]    voice_amplitude,
    output logic [2*VOICES-1:0]        voice_shape,
    output logic [$clog2(VOICES):0]    active_count,
    output logic                       stolen
);

    localparam int c_IDX_W = $clog2(VOICES);
    localparam int c_CNT_W = $clog2(VOICES) + 1;

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_SCAN   = 2'd1;
    localparam logic [1:0] c_COMMIT = 2'd2;

    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(VOICES - 1);

    logic [1:0]         r_state;
    logic [c_IDX_W-1:0] r_idx;

    logic               r_ev_on;
    logic [6:0]         r_ev_key;
    logic [15:0]        r_ev_freq;
    logic [WIDTH-1:0]   r_ev_amp;
    logic [1:0]         r_ev_shape;

    logic               r_hit_vld;
    logic               r_free_vld;
    logic               r_old_vld;
    logic [c_IDX_W-1:0] r_hit_idx;
    logic [c_IDX_W-1:0] r_free_idx;
    logic [c_IDX_W-1:0] r_old_idx;
    logic [7:0]         r_old_age;

    logic [6:0]         r_key [VOICES];
    logic [7:0]         r_age [VOICES];

    logic               w_cur_en;
    logic [6:0]         w_cur_key;
    logic [7:0]         w_cur_age;
    logic               w_commit;
    logic               w_steal;
    logic [c_IDX_W-1:0] w_target;
    logic [VOICES-1:0]  w_en_next;
    logic [c_CNT_W-1:0] w_count_next;

    assign ev_ready  = (r_state == c_IDLE) && !panic && !rst;

    assign w_cur_en  = voice_enable[r_idx];
    assign w_cur_key = r_key[r_idx];
    assign w_cur_age = r_age[r_idx];

    assign w_commit  = (r_state == c_COMMIT);
    // Stealing only happens when neither a retrigger nor a free voice exists.
    assign w_steal   = r_ev_on && !r_hit_vld && !r_free_vld;
    assign w_target  = r_hit_vld ? r_hit_idx : (r_free_vld ? r_free_idx : r_old_idx);

    always_comb begin
        w_en_next = voice_enable;
        if (panic) begin
            w_en_next = '0;
        end else if (w_commit) begin
            if (r_ev_on) begin
                w_en_next[w_target] = 1'b1;
            end else if (r_hit_vld) begin
                w_en_next[r_hit_idx] = 1'b0;
            end
        end
    end

    always_comb begin
        w_count_next = '0;
        for (int i = 0; i < VOICES; i++) begin
            w_count_next = w_count_next + {{(c_CNT_W-1){1'b0}}, w_en_next[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_idx      <= '0;
            r_ev_on    <= 1'b0;
            r_ev_key   <= '0;
            r_ev_freq  <= '0;
            r_ev_amp   <= '0;
            r_ev_shape <= '0;
            r_hit_vld  <= 1'b0;
            r_free_vld <= 1'b0;
            r_old_vld  <= 1'b0;
            r_hit_idx  <= '0;
            r_free_idx <= '0;
            r_old_idx  <= '0;
            r_old_age  <= '0;
        end else if (panic) begin
            r_state <= c_IDLE;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (ev_valid) begin
                        r_ev_on    <= ev_on;
                        r_ev_key   <= ev_key;
                        r_ev_freq  <= ev_freq;
                        r_ev_amp   <= ev_amplitude;
                        r_ev_shape <= ev_shape;
                        r_hit_vld  <= 1'b0;
                        r_free_vld <= 1'b0;
                        r_old_vld  <= 1'b0;
                        r_idx      <= '0;
                        r_state    <= c_SCAN;
                    end
                end
                c_SCAN: begin
                    if (w_cur_en && (w_cur_key == r_ev_key) && !r_hit_vld) begin
                        r_hit_vld <= 1'b1;
                        r_hit_idx <= r_idx;
                    end
                    if (r_ev_on) begin
                        if (!w_cur_en && !r_free_vld) begin
                            r_free_vld <= 1'b1;
                            r_free_idx <= r_idx;
                        end
                        // Strict compare keeps the lowest index on equal ages.
                        if (w_cur_en && (!r_old_vld || (w_cur_age > r_old_age))) begin
                            r_old_vld <= 1'b1;
                            r_old_idx <= r_idx;
                            r_old_age <= w_cur_age;
                        end
                    end
                    if (r_idx == c_LAST_IDX) begin
                        r_state <= c_COMMIT;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                c_COMMIT: r_state <= c_IDLE;
                default:  r_state <= c_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            voice_enable    <= '0;
            voice_freq      <= '0;
            voice_amplitude <= '0;
            voice_shape     <= '0;
            active_count    <= '0;
            stolen          <= 1'b0;
            for (int i = 0; i < VOICES; i++) begin
                r_key[i] <= '0;
                r_age[i] <= '0;
            end
        end else begin
            voice_enable <= w_en_next;
            active_count <= w_count_next;
            stolen       <= !panic && w_commit && w_steal;
            for (int i = 0; i < VOICES; i++) begin
                if (panic) begin
                    r_age[i] <= '0;
                end else if (w_commit && r_ev_on) begin
                    if (c_IDX_W'(i) == w_target) begin
                        r_key[i]                       <= r_ev_key;
                        r_age[i]                       <= '0;
                        voice_freq[16*i +: 16]         <= r_ev_freq;
                        voice_amplitude[WIDTH*i +: WIDTH] <= r_ev_amp;
                        voice_shape[2*i +: 2]          <= r_ev_shape;
                    end else if (voice_enable[i] && (r_age[i] != 8'hFF)) begin
                        r_age[i] <= r_age[i] + 8'd1;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_voice_allocator.sv
`default_nettype none
// ============================================================================
// Module   : tb_voice_allocator
// Brief    : Self-checking bench for voice_allocator (VOICES=4) against a
//            per-voice array model of the allocation rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_voice_allocator;

    localparam int V = 4;
    localparam int W = 24;

    logic              clk = 1'b0;
    logic              rst;
    logic              panic;
    logic              ev_valid;
    logic              ev_ready;
    logic              ev_on;
    logic [6:0]        ev_key;
    logic [15:0]       ev_freq;
    logic [W-1:0]      ev_amplitude;
    logic [1:0]        ev_shape;
    logic [V-1:0]      voice_enable;
    logic [16*V-1:0]   voice_freq;
    logic [W*V-1:0]    voice_amplitude;
    logic [2*V-1:0]    voice_shape;
    logic [2:0]        active_count;
    logic              stolen;

    int n_cmp  = 0;
    int n_fail = 0;

    logic        m_en    [V];
    logic [6:0]  m_key   [V];
    int          m_age   [V];
    logic [15:0] m_freq  [V];
    logic [W-1:0] m_amp  [V];
    logic [1:0]  m_shape [V];

    voice_allocator #(.VOICES(V), .WIDTH(W)) dut (
        .clk             (clk),
        .rst             (rst),
        .panic           (panic),
        .ev_valid        (ev_valid),
        .ev_ready        (ev_ready),
        .ev_on           (ev_on),
        .ev_key          (ev_key),
        .ev_freq         (ev_freq),
        .ev_amplitude    (ev_amplitude),
        .ev_shape        (ev_shape),
        .voice_enable    (voice_enable),
        .voice_freq      (voice_freq),
        .voice_amplitude (voice_amplitude),
        .voice_shape     (voice_shape),
        .active_count    (active_count),
        .stolen          (stolen)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] exp_en();
        logic [127:0] r = '0;
        for (int i = 0; i < V; i++) r[i] = m_en[i];
        return r;
    endfunction

    function automatic logic [127:0] exp_freq();
        logic [127:0] r = '0;
        for (int i = 0; i < V; i++) r[16*i +: 16] = m_freq[i];
        return r;
    endfunction

    function automatic logic [127:0] exp_amp();
        logic [127:0] r = '0;
        for (int i = 0; i < V; i++) r[W*i +: W] = m_amp[i];
        return r;
    endfunction

    function automatic logic [127:0] exp_shape();
        logic [127:0] r = '0;
        for (int i = 0; i < V; i++) r[2*i +: 2] = m_shape[i];
        return r;
    endfunction

    function automatic logic [127:0] exp_count();
        int n = 0;
        for (int i = 0; i < V; i++) n += int'(m_en[i]);
        return 128'(n);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < V; i++) begin
            m_en[i] = 1'b0; m_key[i] = '0; m_age[i] = 0;
            m_freq[i] = '0; m_amp[i] = '0; m_shape[i] = '0;
        end
    endtask

    task automatic model_panic();
        for (int i = 0; i < V; i++) begin
            m_en[i]  = 1'b0;
            m_age[i] = 0;
        end
    endtask

    task automatic model_apply(input logic on, input logic [6:0] key, input logic [15:0] freq,
                               input logic [W-1:0] amp, input logic [1:0] shape, output logic st);
        int hit = -1;
        int free = -1;
        int old = -1;
        int t;
        st = 1'b0;
        for (int i = 0; i < V; i++)
            if (m_en[i] && m_key[i] == key && hit < 0) hit = i;
        if (on) begin
            for (int i = 0; i < V; i++)
                if (!m_en[i] && free < 0) free = i;
            for (int i = 0; i < V; i++)
                if (m_en[i] && (old < 0 || m_age[i] > m_age[old])) old = i;
            if (hit >= 0)       t = hit;
            else if (free >= 0) t = free;
            else begin t = old; st = 1'b1; end
            for (int i = 0; i < V; i++) begin
                if (i == t) begin
                    m_en[i] = 1'b1; m_key[i] = key; m_age[i] = 0;
                    m_freq[i] = freq; m_amp[i] = amp; m_shape[i] = shape;
                end else if (m_en[i]) begin
                    m_age[i] = (m_age[i] < 255) ? m_age[i] + 1 : 255;
                end
            end
        end else if (hit >= 0) begin
            m_en[hit] = 1'b0;
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".enable"}, 128'(voice_enable), exp_en());
        check({tag, ".freq"},   128'(voice_freq), exp_freq());
        check({tag, ".amp"},    128'(voice_amplitude), exp_amp());
        check({tag, ".shape"},  128'(voice_shape), exp_shape());
        check({tag, ".count"},  128'(active_count), exp_count());
    endtask

    task automatic do_reset();
        rst = 1'b1; panic = 1'b0; ev_valid = 1'b0;
        ev_on = 1'b0; ev_key = '0; ev_freq = '0; ev_amplitude = '0; ev_shape = '0;
        step();
        step();
        model_reset();
        check("reset.ready_low", 128'(ev_ready), 128'(0));
        check("reset.stolen", 128'(stolen), 128'(0));
        check_outputs("reset");
        rst = 1'b0;
        #1;
        check("reset.ready_after_release", 128'(ev_ready), 128'(1));
    endtask

    task automatic accept(input logic on, input logic [6:0] key, input logic [15:0] freq,
                          input logic [W-1:0] amp, input logic [1:0] shape);
        int waited = 0;
        while (ev_ready !== 1'b1 && waited < 20) begin
            step();
            waited++;
        end
        check("ready_before_event", 128'(ev_ready), 128'(1));
        ev_valid = 1'b1; ev_on = on; ev_key = key; ev_freq = freq;
        ev_amplitude = amp; ev_shape = shape;
        step();
        ev_valid = 1'b0;
        ev_on = 1'($urandom); ev_key = 7'($urandom); ev_freq = 16'($urandom);
        ev_amplitude = W'($urandom); ev_shape = 2'($urandom);
    endtask

    task automatic send_event(input logic on, input logic [6:0] key, input logic [15:0] freq,
                              input logic [W-1:0] amp, input logic [1:0] shape);
        logic exp_st;
        accept(on, key, freq, amp, shape);
        for (int c = 0; c <= V; c++) begin
            check("busy.ready_low", 128'(ev_ready), 128'(0));
            check("busy.enable_stable", 128'(voice_enable), exp_en());
            step();
        end
        model_apply(on, key, freq, amp, shape, exp_st);
        check_outputs("commit");
        check("commit.stolen", 128'(stolen), 128'(exp_st));
        check("commit.ready_high", 128'(ev_ready), 128'(1));
        step();
        check("stolen_one_cycle", 128'(stolen), 128'(0));
    endtask

    initial begin
        model_reset();

        // Single note-on with latency and ready checks.
        do_reset();
        send_event(1'b1, 7'd60, 16'd440, 24'h7FFFFF, 2'd2);
        check("t1.freq0", 128'(voice_freq[15:0]), 128'(440));
        check("t1.enable", 128'(voice_enable), 128'(4'b0001));

        // Fill all voices, then steal the oldest.
        do_reset();
        send_event(1'b1, 7'd60, 16'd440, 24'h000100, 2'd0);
        send_event(1'b1, 7'd62, 16'd494, 24'h000200, 2'd1);
        send_event(1'b1, 7'd64, 16'd523, 24'h000300, 2'd2);
        send_event(1'b1, 7'd65, 16'd587, 24'h000400, 2'd3);
        send_event(1'b1, 7'd67, 16'd659, 24'h000500, 2'd1);
        check("t2.freq0_stolen", 128'(voice_freq[15:0]), 128'(659));
        check("t2.count", 128'(active_count), 128'(4));

        // Note-off of an active key and of an absent key.
        do_reset();
        send_event(1'b1, 7'd60, 16'd440, 24'h123456, 2'd2);
        send_event(1'b1, 7'd62, 16'd494, 24'h654321, 2'd0);
        send_event(1'b0, 7'd60, 16'd1,   24'h000001, 2'd3);
        check("t3.enable", 128'(voice_enable), 128'(4'b0010));
        check("t3.freq_kept", 128'(voice_freq[15:0]), 128'(440));
        send_event(1'b0, 7'd70, 16'd2,   24'h000002, 2'd1);
        check("t3.noop_enable", 128'(voice_enable), 128'(4'b0010));

        // Retrigger of an already sounding key.
        do_reset();
        send_event(1'b1, 7'd60, 16'd440, 24'h111111, 2'd2);
        send_event(1'b1, 7'd60, 16'd880, 24'h222222, 2'd1);
        check("t4.freq0", 128'(voice_freq[15:0]), 128'(880));
        check("t4.enable", 128'(voice_enable), 128'(4'b0001));

        // Panic during a scan with three voices active.
        do_reset();
        send_event(1'b1, 7'd60, 16'd440, 24'h0000AA, 2'd0);
        send_event(1'b1, 7'd62, 16'd494, 24'h0000BB, 2'd1);
        send_event(1'b1, 7'd64, 16'd523, 24'h0000CC, 2'd2);
        accept(1'b1, 7'd65, 16'd587, 24'h0000DD, 2'd3);
        step();
        panic = 1'b1;
        step();
        panic = 1'b0;
        #1;
        model_panic();
        check_outputs("t5.panic");
        check("t5.ready_after_panic", 128'(ev_ready), 128'(1));
        for (int c = 0; c < V + 2; c++) begin
            step();
            check("t5.dropped_enable", 128'(voice_enable), 128'(0));
        end
        panic = 1'b1;
        #1;
        check("t5.ready_low_panic_idle", 128'(ev_ready), 128'(0));
        ev_valid = 1'b1; ev_on = 1'b1; ev_key = 7'd66;
        step();
        ev_valid = 1'b0; panic = 1'b0;
        #1;
        check("t5.not_accepted_ready", 128'(ev_ready), 128'(1));
        send_event(1'b1, 7'd66, 16'd700, 24'h0000EE, 2'd1);

        // Reset with a commit pending.
        do_reset();
        send_event(1'b1, 7'd60, 16'd440, 24'h0ABCDE, 2'd2);
        accept(1'b1, 7'd62, 16'd494, 24'h0FEDCB, 2'd1);
        for (int c = 0; c < V; c++) step();
        rst = 1'b1;
        step();
        model_reset();
        check("t6.ready_in_reset", 128'(ev_ready), 128'(0));
        check("t6.stolen", 128'(stolen), 128'(0));
        check_outputs("t6.reset");
        rst = 1'b0;
        step();
        check_outputs("t6.after_release");
        check("t6.ready", 128'(ev_ready), 128'(1));

        // Randomized event stream with frequent hits and steals.
        do_reset();
        for (int n = 0; n < 60; n++) begin
            send_event(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
                       7'(60 + $urandom_range(0, 7)),
                       16'($urandom),
                       W'($urandom),
                       2'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
